// File: rtl/apb_cmd_master_if.sv
// Bundles the command, response and APB signals of one bridge instance.
// The master modport is the bridge's view; the slave modport is the surrounding environment's view.
interface apb_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_tmo;

    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB initiator: turns a valid/ready command stream into single APB transfers
// and returns read data / error status on a valid/ready response channel.
module apb_cmd_master #(
    parameter int          TIMEOUT = 16,
    parameter logic [2:0]  PROT    = 3'h0
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    apb_cmd_master_if.master       bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    // Counter only ever reaches TIMEOUT-1, so it needs just enough bits for that value.
    localparam int             CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;

    // NOTE: gating with PRESETn keeps cmd_ready low during reset even though state already reads IDLE.
    assign bus.cmd_ready = (state == IDLE) & PRESETn;
    assign bus.PPROT     = PROT;

    // NOTE: every register here is sequential state, so only non-blocking assignments are used.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.PSTRB     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_tmo   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.PADDR   <= bus.cmd_addr;
                        bus.PWDATA  <= bus.cmd_wdata;
                        bus.PWRITE  <= bus.cmd_write;
                        bus.PSTRB   <= bus.cmd_write ? bus.cmd_strb : 4'h0;
                        bus.PSEL    <= 1'b1;
                        bus.PENABLE <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over the watchdog on the limit cycle.
                    if (bus.PREADY) begin
                        bus.PSEL      <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_rdata <= bus.PWRITE ? 32'h0 : bus.PRDATA;
                        bus.rsp_err   <= bus.PSLVERR;
                        bus.rsp_tmo   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (TIMEOUT != 0 && wait_cnt == LIMIT) begin
                        bus.PSEL      <= 1'b0;
                        bus.PENABLE   <= 1'b0;
                        bus.rsp_rdata <= 32'hFFFF_FFFF;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_tmo   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: each task drives one scenario and compares
// outputs sampled 1 time unit after the rising edge against hand-computed values.
module tb_apb_cmd_master;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    apb_cmd_master_if bus();

    apb_cmd_master #(.TIMEOUT(16), .PROT(3'h5)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, time=%0t expected end before 200000", $time);
        $fatal(1, "global timeout");
    end

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    // Presents one command for a single edge; caller has already seen cmd_ready=1.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_strb  = s;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic take_rsp;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++;
        if ({bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.rsp_tmo} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.rsp_tmo});
        end
        checks++;
        if ({bus.PADDR, bus.PWDATA, bus.rsp_rdata, bus.PSTRB} !== 100'h0) begin
            errors++;
            $display("FAIL reset_data: got PADDR=%h PWDATA=%h rdata=%h PSTRB=%h expected all 0",
                     bus.PADDR, bus.PWDATA, bus.rsp_rdata, bus.PSTRB);
        end
        checks++;
        if (bus.PPROT !== 3'h5) begin
            errors++;
            $display("FAIL pprot: got %h expected 5", bus.PPROT);
        end
        PRESETn = 1'b1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write;
        bus.PREADY = 1'b1;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.cmd_ready} !== 5'b10100) begin
            errors++;
            $display("FAIL write_setup: got PSEL/PEN/PWRITE/rsp_valid/cmd_ready=%b expected 10100",
                     {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.cmd_ready});
        end
        checks++;
        if ({bus.PADDR, bus.PWDATA, bus.PSTRB} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin
            errors++;
            $display("FAIL write_payload: got %h/%h/%h expected 00000010/deadbeef/f",
                     bus.PADDR, bus.PWDATA, bus.PSTRB);
        end
        tick();
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110) begin
            errors++;
            $display("FAIL write_access: got PSEL/PEN/rsp_valid=%b expected 110",
                     {bus.PSEL, bus.PENABLE, bus.rsp_valid});
        end
        tick();
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_err, bus.rsp_tmo} !== 5'b00100 ||
            bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL write_rsp: got PSEL/PEN/valid/err/tmo=%b rdata=%h expected 00100 rdata=00000000",
                     {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_err, bus.rsp_tmo}, bus.rsp_rdata);
        end
        take_rsp();
        checks++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL write_handshake: got rsp_valid/cmd_ready=%b expected 01", {bus.rsp_valid, bus.cmd_ready});
        end
    endtask

    task automatic test_read_wait;
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hDEADBEEF;
        issue(1'b0, 32'h10, 32'h0, 4'hF);
        checks++;
        if ({bus.PWRITE, bus.PSTRB} !== 5'b0) begin
            errors++;
            $display("FAIL read_strb: got PWRITE=%b PSTRB=%h expected 0/0", bus.PWRITE, bus.PSTRB);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110 || bus.PADDR !== 32'h10) begin
                errors++;
                $display("FAIL read_access_hold%0d: got PSEL/PEN/valid=%b PADDR=%h expected 110 PADDR=00000010",
                         i, {bus.PSEL, bus.PENABLE, bus.rsp_valid}, bus.PADDR);
            end
            if (i == 3) bus.PREADY = 1'b1;
            tick();
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_tmo, bus.PSEL} !== 4'b1000 || bus.rsp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_rsp: got valid/err/tmo/PSEL=%b rdata=%h expected 1000 rdata=deadbeef",
                     {bus.rsp_valid, bus.rsp_err, bus.rsp_tmo, bus.PSEL}, bus.rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_slverr;
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        issue(1'b1, 32'h24, 32'h0000_1111, 4'h3);
        tick();
        tick();
        bus.PSLVERR = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_tmo} !== 3'b110 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL slverr_rsp: got valid/err/tmo=%b rdata=%h expected 110 rdata=00000000",
                     {bus.rsp_valid, bus.rsp_err, bus.rsp_tmo}, bus.rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_timeout;
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h1234_5678;
        issue(1'b0, 32'h40, 32'h0, 4'h0);
        tick();
        // 15 wait-state edges must not end the transfer; the 16th aborts it.
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110) begin
            errors++;
            $display("FAIL tmo_early: got PSEL/PEN/valid=%b after 15 waits expected 110",
                     {bus.PSEL, bus.PENABLE, bus.rsp_valid});
        end
        tick();
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_err, bus.rsp_tmo} !== 5'b00111 ||
            bus.rsp_rdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL tmo_abort: got PSEL/PEN/valid/err/tmo=%b rdata=%h expected 00111 rdata=ffffffff",
                     {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_err, bus.rsp_tmo}, bus.rsp_rdata);
        end
        take_rsp();

        // Same wait, but the slave answers on the 16th ACCESS cycle; rsp_ready is already high.
        issue(1'b0, 32'h44, 32'h0, 4'h0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        bus.PREADY    = 1'b1;
        bus.rsp_ready = 1'b1;
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_tmo} !== 3'b100 || bus.rsp_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL tmo_ready_wins: got valid/err/tmo=%b rdata=%h expected 100 rdata=12345678",
                     {bus.rsp_valid, bus.rsp_err, bus.rsp_tmo}, bus.rsp_rdata);
        end
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL early_ready_handshake: got rsp_valid/cmd_ready=%b expected 01",
                     {bus.rsp_valid, bus.cmd_ready});
        end
    endtask

    task automatic test_back_to_back;
        bus.PREADY    = 1'b1;
        bus.PRDATA    = 32'hCAFE_0001;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h100;
        bus.cmd_wdata = 32'h5555_AAAA;
        bus.cmd_strb  = 4'h5;
        tick();
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h200;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.cmd_ready, bus.rsp_valid, bus.PSEL} !== 3'b010 || bus.PADDR !== 32'h100) begin
                errors++;
                $display("FAIL b2b_stall%0d: got cmd_ready/rsp_valid/PSEL=%b PADDR=%h expected 010 PADDR=00000100",
                         i, {bus.cmd_ready, bus.rsp_valid, bus.PSEL}, bus.PADDR);
            end
            tick();
        end
        take_rsp();
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.PSEL} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_handshake: got cmd_ready/rsp_valid/PSEL=%b expected 100",
                     {bus.cmd_ready, bus.rsp_valid, bus.PSEL});
        end
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b100 || bus.PADDR !== 32'h200) begin
            errors++;
            $display("FAIL b2b_second_setup: got PSEL/PEN/PWRITE=%b PADDR=%h expected 100 PADDR=00000200",
                     {bus.PSEL, bus.PENABLE, bus.PWRITE}, bus.PADDR);
        end
        tick();
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL b2b_second_rsp: got valid=%b rdata=%h expected 1 rdata=cafe0001",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_reset_mid;
        bus.PREADY = 1'b0;
        issue(1'b1, 32'h300, 32'h0BAD_F00D, 4'hF);
        tick();
        #2;
        PRESETn = 1'b0;
        #1;
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: got PSEL/PEN/valid/cmd_ready=%b expected 0000",
                     {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready});
        end
        tick();
        PRESETn    = 1'b1;
        bus.PREADY = 1'b1;
        #1;
        issue(1'b1, 32'h304, 32'h0000_00FF, 4'h1);
        tick();
        tick();
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_tmo} !== 3'b100 || bus.PADDR !== 32'h304) begin
            errors++;
            $display("FAIL after_reset_xfer: got valid/err/tmo=%b PADDR=%h expected 100 PADDR=00000304",
                     {bus.rsp_valid, bus.rsp_err, bus.rsp_tmo}, bus.PADDR);
        end
        take_rsp();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b0;

        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
